// File: rtl/calc_exec_unit_pkg.sv
// Shared encodings for the calculator execution stage: operation codes,
// control-bus codes and the execution state machine states.
package calc_exec_unit_pkg;

  // Operation select codes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Shared control bus codes (only CLEAR and EQUALS matter to this stage)
  localparam logic [2:0] SEL_LOAD_A = 3'b001;
  localparam logic [2:0] SEL_CLEAR  = 3'b100;
  localparam logic [2:0] SEL_EQUALS = 3'b111;

  // Execution state machine
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/calc_iter_muldiv.sv
// Iterative multiply/divide datapath shared by MUL and DIV.
// One 2*WIDTH accumulator serves both algorithms:
//   mul: {partial sum, remaining multiplier bits}, shift right each step
//   div: {partial remainder, remaining dividend / quotient bits}, shift left
// 'start' loads the operands; each 'step' performs one iteration. 'done'
// flags the step that completes the last iteration, and 'result' is the
// value the accumulator takes at that step, so the caller can register it
// on the same edge.
module calc_iter_muldiv #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               step,
  input  logic               mode,     // 0: multiply, 1: divide
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               mode_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
              + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    rem_diff  = rem_shift - {1'b0, opnd_reg};
    acc_next  = acc_reg;
    if (!mode_reg) begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end else if (!rem_diff[WIDTH]) begin
      acc_next = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Operand load on start, one iteration per enabled step
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg   <= '0;
      opnd_reg  <= '0;
      mode_reg  <= 1'b0;
      count_reg <= '0;
    end else if (start) begin
      acc_reg   <= {{WIDTH{1'b0}}, a};
      opnd_reg  <= b;
      mode_reg  <= mode;
      count_reg <= '0;
    end else if (step) begin
      acc_reg   <= acc_next;
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done   = step && (count_reg == CNT_W'(ITER - 1));
  assign result = acc_next;

endmodule

// File: rtl/calc_exec_unit.sv
// Calculator execution stage: detects the EQUALS edge on the control bus,
// latches operands, runs add/sub in one cycle or mul/div over ITER cycles,
// and presents a registered result with a done pulse and sticky error flag.
module calc_exec_unit
  import calc_exec_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         Op,
  input  logic [2:0]         Sel,
  output logic [2*WIDTH-1:0] Result,
  output logic               Done,
  output logic               Busy,
  output logic               Err
);

  state_t             state;
  logic [2:0]         sel_prev;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [1:0]         op_reg;

  logic               start;
  logic               clear;
  logic               md_start;
  logic               md_step;
  logic               md_done;
  logic [2*WIDTH-1:0] md_result;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               exec_done;
  logic               exec_err;
  logic [2*WIDTH-1:0] exec_result;

  assign start = (Sel == SEL_EQUALS) && (sel_prev != SEL_EQUALS);
  assign clear = (Sel == SEL_CLEAR);

  // The iterative unit loads straight from the live operands on the same
  // edge the top latches them, so both copies are identical.
  assign md_start = (state == ST_IDLE) && start && !clear && Op[1];
  assign md_step  = (state == ST_EXEC) && !clear &&
                    ((op_reg == OP_MUL) || ((op_reg == OP_DIV) && (b_reg != '0)));

  calc_iter_muldiv #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_muldiv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (md_start),
    .step    (md_step),
    .mode    (Op[0]),
    .a       (A),
    .b       (B),
    .done    (md_done),
    .result  (md_result)
  );

  assign add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_diff = {1'b0, a_reg} - {1'b0, b_reg};

  // Select the completing value for the latched operation
  always_comb begin
    exec_done   = 1'b0;
    exec_err    = 1'b0;
    exec_result = md_result;
    case (op_reg)
      OP_ADD: begin
        exec_done   = 1'b1;
        exec_result = {{(WIDTH-1){1'b0}}, add_sum};
      end
      OP_SUB: begin
        exec_done   = 1'b1;
        exec_result = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
      end
      OP_MUL: begin
        exec_done = md_done;
      end
      OP_DIV: begin
        if (b_reg == '0) begin
          exec_done   = 1'b1;
          exec_err    = 1'b1;
          exec_result = '0;
        end else begin
          exec_done = md_done;
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs; clear overrides everything
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sel_prev <= 3'b000;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= OP_ADD;
      Result   <= '0;
      Done     <= 1'b0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      sel_prev <= Sel;
      if (clear) begin
        Result <= '0;
        Err    <= 1'b0;
        Done   <= 1'b0;
        Busy   <= 1'b0;
        state  <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            Done <= 1'b0;
            if (start) begin
              a_reg  <= A;
              b_reg  <= B;
              op_reg <= Op;
              Busy   <= 1'b1;
              state  <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (exec_done) begin
              Result <= exec_result;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              state  <= ST_DONE;
              if (exec_err) begin
                Err <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            Done  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_exec_unit.sv
// Self-checking bench for calc_exec_unit: expected results are pushed to a
// scoreboard queue when an operation is started and popped when Done rises.
module tb_calc_exec_unit;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  A       = '0;
  logic [7:0]  B       = '0;
  logic [1:0]  Op      = '0;
  logic [2:0]  Sel     = '0;
  logic [15:0] Result;
  logic        Done;
  logic        Busy;
  logic        Err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_pulses = 0;
  logic err_state = 1'b0;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];

  calc_exec_unit #(
    .WIDTH (8),
    .ITER  (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .Op      (Op),
    .Sel     (Sel),
    .Result  (Result),
    .Done    (Done),
    .Busy    (Busy),
    .Err     (Err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (Done === 1'b1) done_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  // Reference arithmetic, also tracking the sticky error flag
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    exp_t e;
    e.err = err_state;
    case (op)
      2'b00: e.res = {8'h00, a} + {8'h00, b};
      2'b01: e.res = {8'h00, a} - {8'h00, b};
      2'b10: e.res = 16'(a) * 16'(b);
      default: begin
        if (b == 8'd0) begin
          e.res = 16'd0;
          e.err = 1'b1;
        end else begin
          e.res = {8'(a % b), 8'(a / b)};
        end
      end
    endcase
    return e;
  endfunction

  function automatic int exp_latency(input logic [7:0] b, input logic [1:0] op);
    if (op == 2'b10 || (op == 2'b11 && b != 8'd0)) return 8;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One idle cycle, then an EQUALS edge sampled at the next edge (edge 0)
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    Sel = 3'b000;
    tick();
    A = a; B = b; Op = op; Sel = 3'b111;
    tick();
    Sel = 3'b000;
  endtask

  // Edges after edge 0 until Done is seen; -1 if the budget runs out
  task automatic wait_done(input int max_edges, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (Done !== 1'b1 && edges < max_edges);
    if (Done !== 1'b1) edges = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    Sel = 3'b000;
    repeat (2) tick();
    n_cmp++; if (Result !== 16'd0) begin n_bad++; $display("FAIL reset_result: got %h expected %h", Result, 16'd0); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", Done); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if (Err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", Err); end
    $display("reset: Result=%h Done=%b Busy=%b Err=%b", Result, Done, Busy, Err);
    reset_n = 1'b1;
    err_state = 1'b0;
    tick();
  endtask

  task automatic test_add();
    exp_t e;
    int lat;
    sb.push_back(model(8'd200, 8'd100, 2'b00));
    start_op(8'd200, 8'd100, 2'b00);
    wait_done(20, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency: got %0d expected 1", lat); end
    e = sb.pop_front();
    n_cmp++; if (Result !== e.res) begin n_bad++; $display("FAIL add_result: got %h expected %h", Result, e.res); end
    n_cmp++; if (Err !== e.err) begin n_bad++; $display("FAIL add_err: got %b expected %b", Err, e.err); end
    $display("add 200+100: Result=%h latency=%0d", Result, lat);
    tick();
    n_cmp++; if ({Busy, Done} !== 2'b00) begin n_bad++; $display("FAIL add_idle: got busy/done %b expected 00", {Busy, Done}); end
  endtask

  task automatic test_sub_hold();
    exp_t e;
    int p0;
    Sel = 3'b000;
    tick();
    p0 = done_pulses;
    sb.push_back(model(8'd5, 8'd9, 2'b01));
    A = 8'd5; B = 8'd9; Op = 2'b01; Sel = 3'b111;
    repeat (5) tick();
    Sel = 3'b000;
    repeat (3) tick();
    n_cmp++; if (done_pulses - p0 !== 1) begin n_bad++; $display("FAIL hold_pulses: got %0d expected 1", done_pulses - p0); end
    e = sb.pop_front();
    n_cmp++; if (Result !== e.res) begin n_bad++; $display("FAIL sub_result: got %h expected %h", Result, e.res); end
    $display("sub 5-9 held equals: Result=%h pulses=%0d", Result, done_pulses - p0);
  endtask

  task automatic test_mul();
    exp_t e;
    int lat;
    int busy_cnt;
    sb.push_back(model(8'd255, 8'd255, 2'b10));
    start_op(8'd255, 8'd255, 2'b10);
    busy_cnt = (Busy === 1'b1) ? 1 : 0;
    lat = -1;
    for (int ed = 1; ed <= 20; ed++) begin
      tick();
      if (ed == 3) A = 8'd0;
      if (Done === 1'b1) begin
        lat = ed;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
    end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL mul_latency: got %0d expected 8", lat); end
    n_cmp++; if (busy_cnt !== 8) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d expected 8", busy_cnt); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_end: got %b expected 0", Busy); end
    e = sb.pop_front();
    n_cmp++; if (Result !== e.res) begin n_bad++; $display("FAIL mul_result: got %h expected %h", Result, e.res); end
    $display("mul 255*255: Result=%h latency=%0d busy=%0d", Result, lat, busy_cnt);
  endtask

  task automatic test_div();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [1:0] to [3];
    exp_t e;
    int lat;
    ta = '{8'd200, 8'd200, 8'd1};
    tb = '{8'd7,   8'd0,   8'd1};
    to = '{2'b11,  2'b11,  2'b00};
    for (int i = 0; i < 3; i++) begin
      e = model(ta[i], tb[i], to[i]);
      err_state = e.err;
      sb.push_back(e);
      start_op(ta[i], tb[i], to[i]);
      wait_done(20, lat);
      n_cmp++; if (lat !== exp_latency(tb[i], to[i])) begin n_bad++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(tb[i], to[i])); end
      e = sb.pop_front();
      n_cmp++; if (Result !== e.res) begin n_bad++; $display("FAIL div_result[%0d]: got %h expected %h", i, Result, e.res); end
      n_cmp++; if (Err !== e.err) begin n_bad++; $display("FAIL div_err[%0d]: got %b expected %b", i, Err, e.err); end
      $display("op%0d a=%0d b=%0d: Result=%h Err=%b latency=%0d", to[i], ta[i], tb[i], Result, Err, lat);
    end
  endtask

  task automatic test_clear_mid();
    exp_t e;
    int p0;
    int lat;
    start_op(8'd13, 8'd11, 2'b10);
    p0 = done_pulses;
    repeat (3) tick();
    Sel = 3'b100;
    tick();
    err_state = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL clear_busy: got %b expected 0", Busy); end
    n_cmp++; if (Result !== 16'd0) begin n_bad++; $display("FAIL clear_result: got %h expected 0000", Result); end
    n_cmp++; if (Err !== 1'b0) begin n_bad++; $display("FAIL clear_err: got %b expected 0", Err); end
    Sel = 3'b000;
    tick();
    n_cmp++; if (done_pulses - p0 !== 0) begin n_bad++; $display("FAIL clear_no_done: got %0d pulses expected 0", done_pulses - p0); end
    $display("clear mid-mul: Result=%h Busy=%b Err=%b", Result, Busy, Err);
    e = model(8'd3, 8'd4, 2'b00);
    sb.push_back(e);
    A = 8'd3; B = 8'd4; Op = 2'b00; Sel = 3'b111;
    tick();
    Sel = 3'b000;
    wait_done(20, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL after_clear_latency: got %0d expected 1", lat); end
    e = sb.pop_front();
    n_cmp++; if (Result !== e.res) begin n_bad++; $display("FAIL after_clear_result: got %h expected %h", Result, e.res); end
    $display("add 3+4 after clear: Result=%h", Result);
  endtask

  task automatic test_async_reset();
    exp_t e;
    int lat;
    start_op(8'd100, 8'd3, 2'b10);
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b expected 0", Busy); end
    n_cmp++; if (Result !== 16'd0) begin n_bad++; $display("FAIL areset_result: got %h expected 0000", Result); end
    n_cmp++; if ({Done, Err} !== 2'b00) begin n_bad++; $display("FAIL areset_flags: got %b expected 00", {Done, Err}); end
    $display("async reset mid-mul: Result=%h Busy=%b", Result, Busy);
    sb.delete();
    err_state = 1'b0;
    tick();
    reset_n = 1'b1;
    e = model(8'd10, 8'd20, 2'b00);
    sb.push_back(e);
    start_op(8'd10, 8'd20, 2'b00);
    wait_done(20, lat);
    e = sb.pop_front();
    n_cmp++; if (Result !== e.res || lat !== 1) begin n_bad++; $display("FAIL after_reset_add: got %h lat %0d expected %h lat 1", Result, lat, e.res); end
    $display("add 10+20 after reset: Result=%h latency=%0d", Result, lat);
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    for (int i = 0; i < 16; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = (i % 5 == 4) ? 8'd0 : 8'($urandom_range(0, 255));
      op = 2'($urandom_range(0, 3));
      e = model(a, b, op);
      err_state = e.err;
      sb.push_back(e);
      start_op(a, b, op);
      wait_done(20, lat);
      n_cmp++; if (lat !== exp_latency(b, op)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(b, op)); end
      if (sb.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL rand_sb_empty[%0d]: got empty expected entry", i);
      end else begin
        e = sb.pop_front();
        n_cmp++; if ({Result, Err} !== {e.res, e.err}) begin n_bad++; $display("FAIL rand_result[%0d]: got %h/%b expected %h/%b", i, Result, Err, e.res, e.err); end
      end
      $display("rand op%0d a=%0d b=%0d: Result=%h Err=%b latency=%0d", op, a, b, Result, Err, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_hold();
    test_mul();
    test_div();
    test_clear_mid();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_exec_unit.md
Name: calc_exec_unit

Overview:
- Execution stage directly downstream of the operand holders: consumes held operands A and B plus the shared 3-bit Sel control bus.
- Performs add, subtract, multiply or divide when the "equals" code appears on Sel.
- Add and subtract take one cycle; multiply uses an iterative 8-step shift-add; divide uses an 8-step restoring algorithm.
- Drives a 16-bit result register with a done pulse and error flag to the display/output stage.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH.
- ITER, 8, multiply/divide iteration count; must equal WIDTH.

Ports:
- clock  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- A  input  WIDTH  held operand A
- B  input  WIDTH  held operand B
- Op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div
- Sel  input  3  control bus: 100 clear, 111 equals/start; other codes ignored here
- Result  output  2*WIDTH  registered result
- Done  output  1  one-cycle pulse when Result is updated
- Busy  output  1  high while an operation is executing
- Err  output  1  sticky divide-by-zero flag

Behaviour:
- Single clock domain: clock. reset_n is asynchronous and active-low.
- Reset values: Result=0, Done=0, Busy=0, Err=0, state=IDLE, sel_prev=000, iteration counter=0.
- Start detection:
  - start = (Sel==111) && (sel_prev!=111).
  - sel_prev is registered every cycle, so holding 111 starts exactly one operation.
- Clear:
  - Sel==100 in any state: at the next edge Result=0, Err=0, Done=0, Busy=0, state=IDLE.
  - Clear aborts any in-flight operation and has priority over start.
- State machine states: IDLE, EXEC, DONE.
- IDLE:
  - On start, latch A, B, Op into internal registers; go to EXEC; Busy=1; counter=0.
  - Start is accepted only in IDLE. Start edges in EXEC or DONE are ignored and not queued.
- EXEC, add: Result = zero-extended A+B (9 significant bits). Written at the first edge in EXEC.
- EXEC, sub: Result = A-B as a 9-bit two's-complement value, sign-extended to 16 bits. Written at the first edge in EXEC.
- EXEC, mul:
  - Unsigned shift-add, one partial product per edge for ITER edges.
  - Accumulator and multiplier shift registers are internal.
  - Result written at the ITER-th edge in EXEC and equals A*B exactly.
- EXEC, div:
  - If latched B==0: at the first edge in EXEC, Result=0 and Err=1; go to DONE.
  - Otherwise: unsigned restoring division, one quotient bit per edge for ITER edges.
  - Result = {remainder[7:0], quotient[7:0]}, written at the ITER-th edge.
- EXEC to DONE: on the edge that writes Result, set Busy=0 and Done=1, and go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE with Done=0.
- Latency, counting the start-sampling edge as edge 0:
  - Done is high in the cycle after edge 1 for add, sub and div-by-zero.
  - Done is high in the cycle after edge 8 for mul and div.
- Result holds its value until the next completion or clear.
- Err stays set until clear or reset. A later successful operation does not clear Err.
- Operand changes on A, B or Op during EXEC have no effect, because the operands were latched at start.
- If reset_n is asserted mid-operation, all registers return to reset values immediately.

Decomposition:
- Shared package holds:
  - Op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - Sel codes SEL_LOAD_A=001, SEL_CLEAR=100, SEL_EQUALS=111.
  - State encodings.
- One natural sub-module, calc_iter_muldiv: the shared 8-step shift-add/restoring datapath, with start, mode, a, b inputs and done, result outputs.
- The top-level module holds the FSM, edge detect, add/sub logic and the output registers.

Test Plan:
- Reset with Sel=000, then A=200, B=100, Op=00, Sel 000→111 → Done one cycle after edge 1; Result=16'd300; Busy returns to 0; Err=0.
- A=5, B=9, Op=01, start → Result=16'hFFFC (-4); with Sel held at 111 for 5 cycles → exactly one Done pulse.
- A=255, B=255, Op=10, start → Busy high for 8 cycles; Done after edge 8; Result=16'hFE01. Changing A to 0 mid-operation does not alter the result.
- A=200, B=7, Op=11 → Result={8'd4, 8'd28}. Then B=0, Op=11 → Result=0 and Err=1 after edge 1. A following add with A=1, B=1 → Result=2 and Err stays 1.
- Start a mul, then Sel=100 at the 4th EXEC cycle → next edge: Busy=0, Result=0, Err=0, no Done pulse. A new start one cycle later is accepted.
- Start a mul, then assert reset_n=0 asynchronously between edges → all outputs drop to 0 immediately without a clock edge. After release, a new add completes normally.
